// File: rtl/anita3_buffer_scheduler.sv
// anita3_buffer_scheduler
// Allocates the four digitizer hold buffers (A-D, index 0-3) to incoming
// triggers in round-robin order, issues a one-cycle digitize strobe with the
// chosen buffer, latched trigger source and hold snapshot for the event
// generator, tracks which buffers are held until readout releases them, and
// keeps saturating deadtime and dropped-trigger counters.
//
// Ports:
//   clk125_i          sole clock (trigger domain)
//   rst_i             asynchronous active-high reset
//   enable_i          trigger acceptance enable
//   trig_i            single-cycle trigger pulse
//   trig_source_i     trigger source code, sampled with trig_i
//   clear_i           per-buffer release pulses
//   cnt_reset_i       synchronous clear of both counters
//   digitize_o        one-cycle digitize strobe
//   digitize_buffer_o allocated buffer index
//   digitize_source_o latched trigger source
//   buffer_status_o   hold mask snapshot including the new buffer
//   held_o            live hold mask
//   busy_o            high during ISSUE/HOLDOFF
//   dead_o            all four buffers held
//   deadtime_o        saturating dead-cycle count
//   dropped_o         saturating dropped-trigger count
module anita3_buffer_scheduler #(
  parameter int HOLDOFF        = 8,
  parameter int DEADTIME_WIDTH = 32,
  parameter int DROP_WIDTH     = 16
) (
  input  logic                      clk125_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      trig_i,
  input  logic [3:0]                trig_source_i,
  input  logic [3:0]                clear_i,
  input  logic                      cnt_reset_i,
  output logic                      digitize_o,
  output logic [1:0]                digitize_buffer_o,
  output logic [3:0]                digitize_source_o,
  output logic [3:0]                buffer_status_o,
  output logic [3:0]                held_o,
  output logic                      busy_o,
  output logic                      dead_o,
  output logic [DEADTIME_WIDTH-1:0] deadtime_o,
  output logic [DROP_WIDTH-1:0]     dropped_o
);

  localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // First free buffer starting at the round-robin pointer. Scanning offsets
  // from 3 down to 0 lets the smallest free offset overwrite the others.
  function automatic logic [1:0] pick_free(input logic [3:0] held, input logic [1:0] rr);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = rr;
    for (int i = 3; i >= 0; i--) begin
      idx = rr + 2'(i);
      if (!held[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  state_t                    state_r, state_s;
  logic [HC_W-1:0]           hold_cnt_r, hold_cnt_s;
  logic [3:0]                held_r, held_s;
  logic [1:0]                rr_r;
  logic [1:0]                pick_s;
  logic                      accept_s;
  logic                      drop_s;
  logic                      digitize_r;
  logic [1:0]                buffer_r;
  logic [3:0]                source_r;
  logic [3:0]                status_r;
  logic                      busy_r;
  logic                      dead_r;
  logic [DEADTIME_WIDTH-1:0] deadtime_r;
  logic [DROP_WIDTH-1:0]     dropped_r;

  // Accept/drop decision, allocation, and next hold mask.
  always_comb begin
    accept_s = trig_i & enable_i & (state_r == ST_IDLE) & (held_r != 4'hF);
    drop_s   = trig_i & enable_i & ~accept_s;
    pick_s   = pick_free(held_r, rr_r);
    // A chosen buffer is always free in held_r, so clear and set never meet.
    if (accept_s) begin
      held_s = (held_r & ~clear_i) | onehot4(pick_s);
    end else begin
      held_s = held_r & ~clear_i;
    end
  end

  // Sequencer next-state and holdoff counter.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s    = ST_HOLDOFF;
        hold_cnt_s = '0;
      end
      ST_HOLDOFF: begin
        if (hold_cnt_r == HC_W'(HOLDOFF - 1)) begin
          state_s = ST_IDLE;
        end else begin
          hold_cnt_s = hold_cnt_r + HC_W'(1);
        end
      end
      default: begin
        state_s    = ST_IDLE;
        hold_cnt_s = '0;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk125_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
    end
  end

  // Hold mask, round-robin pointer and registered strobe/status outputs.
  always_ff @(posedge clk125_i or posedge rst_i) begin
    if (rst_i) begin
      held_r     <= 4'b0000;
      rr_r       <= 2'd0;
      digitize_r <= 1'b0;
      buffer_r   <= 2'd0;
      source_r   <= 4'h0;
      status_r   <= 4'b0000;
      busy_r     <= 1'b0;
      dead_r     <= 1'b0;
    end else begin
      held_r     <= held_s;
      digitize_r <= accept_s;
      busy_r     <= (state_s != ST_IDLE);
      dead_r     <= (held_s == 4'hF);
      if (accept_s) begin
        buffer_r <= pick_s;
        source_r <= trig_source_i;
        // Snapshot uses the pre-clear mask plus the new buffer.
        status_r <= held_r | onehot4(pick_s);
        rr_r     <= pick_s + 2'd1;
      end
    end
  end

  // Saturating deadtime and dropped-trigger counters; cnt_reset_i wins.
  always_ff @(posedge clk125_i or posedge rst_i) begin
    if (rst_i) begin
      deadtime_r <= '0;
      dropped_r  <= '0;
    end else if (cnt_reset_i) begin
      deadtime_r <= '0;
      dropped_r  <= '0;
    end else begin
      if (dead_r && !(&deadtime_r)) begin
        deadtime_r <= deadtime_r + DEADTIME_WIDTH'(1);
      end
      if (drop_s && !(&dropped_r)) begin
        dropped_r <= dropped_r + DROP_WIDTH'(1);
      end
    end
  end

  assign digitize_o        = digitize_r;
  assign digitize_buffer_o = buffer_r;
  assign digitize_source_o = source_r;
  assign buffer_status_o   = status_r;
  assign held_o            = held_r;
  assign busy_o            = busy_r;
  assign dead_o            = dead_r;
  assign deadtime_o        = deadtime_r;
  assign dropped_o         = dropped_r;

endmodule

// File: tb/tb_anita3_buffer_scheduler.sv
// Self-checking bench for anita3_buffer_scheduler. A cycle model tracks the
// hold mask, round-robin pointer, busy window and counters; every accepted
// trigger pushes its expected strobe contents to a scoreboard queue that is
// popped when the DUT raises digitize_o.
module tb_anita3_buffer_scheduler;

  localparam int HOLDOFF = 8;

  logic        clk125_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        trig_i = 1'b0;
  logic [3:0]  trig_source_i = 4'h0;
  logic [3:0]  clear_i = 4'h0;
  logic        cnt_reset_i = 1'b0;
  logic        digitize_o;
  logic [1:0]  digitize_buffer_o;
  logic [3:0]  digitize_source_o;
  logic [3:0]  buffer_status_o;
  logic [3:0]  held_o;
  logic        busy_o;
  logic        dead_o;
  logic [31:0] deadtime_o;
  logic [15:0] dropped_o;

  anita3_buffer_scheduler #(
    .HOLDOFF(HOLDOFF), .DEADTIME_WIDTH(32), .DROP_WIDTH(16)
  ) dut (
    .clk125_i(clk125_i), .rst_i(rst_i), .enable_i(enable_i), .trig_i(trig_i),
    .trig_source_i(trig_source_i), .clear_i(clear_i), .cnt_reset_i(cnt_reset_i),
    .digitize_o(digitize_o), .digitize_buffer_o(digitize_buffer_o),
    .digitize_source_o(digitize_source_o), .buffer_status_o(buffer_status_o),
    .held_o(held_o), .busy_o(busy_o), .dead_o(dead_o),
    .deadtime_o(deadtime_o), .dropped_o(dropped_o)
  );

  always #4 clk125_i = ~clk125_i;

  typedef struct packed {
    logic [1:0] buf_idx;
    logic [3:0] src;
    logic [3:0] status;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [3:0]  held_m;
  logic [1:0]  rr_m;
  int          busy_m;
  logic        dig_m;
  logic [1:0]  buf_m;
  logic [3:0]  src_m;
  logic [3:0]  st_m;
  logic [31:0] deadtime_m;
  logic [15:0] dropped_m;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    held_m = 4'h0; rr_m = 2'd0; busy_m = 0; dig_m = 1'b0;
    buf_m = 2'd0; src_m = 4'h0; st_m = 4'h0;
    deadtime_m = 32'd0; dropped_m = 16'd0;
  endtask

  task automatic check_all();
    chk("digitize", {31'd0, digitize_o}, {31'd0, dig_m});
    chk("buffer",   {30'd0, digitize_buffer_o}, {30'd0, buf_m});
    chk("source",   {28'd0, digitize_source_o}, {28'd0, src_m});
    chk("status",   {28'd0, buffer_status_o}, {28'd0, st_m});
    chk("held",     {28'd0, held_o}, {28'd0, held_m});
    chk("busy",     {31'd0, busy_o}, (busy_m > 0) ? 32'd1 : 32'd0);
    chk("dead",     {31'd0, dead_o}, (held_m == 4'hF) ? 32'd1 : 32'd0);
    chk("dropped",  {16'd0, dropped_o}, {16'd0, dropped_m});
    chk("deadtime", deadtime_o, deadtime_m);
  endtask

  // One clock cycle: drive inputs, advance the model across the edge, check.
  task automatic step(input logic t, input logic [3:0] s, input logic [3:0] c,
                      input logic e, input logic cr);
    logic       acc;
    logic       dead_pre;
    logic [1:0] pick;
    logic       found;
    trig_i = t; trig_source_i = s; clear_i = c; enable_i = e; cnt_reset_i = cr;
    acc      = t & e & (busy_m == 0) & (held_m != 4'hF);
    dead_pre = (held_m == 4'hF);
    @(posedge clk125_i);
    dig_m = acc;
    if (acc) begin
      found = 1'b0;
      pick  = 2'd0;
      for (int i = 0; i < 4; i++) begin
        if (!found && !held_m[(rr_m + i) % 4]) begin
          pick  = 2'((rr_m + i) % 4);
          found = 1'b1;
        end
      end
      buf_m = pick;
      src_m = s;
      st_m  = held_m | (4'b0001 << pick);
      sb_q.push_back('{buf_idx: pick, src: s, status: st_m});
      held_m = (held_m & ~c) | (4'b0001 << pick);
      rr_m   = pick + 2'd1;
      busy_m = HOLDOFF + 1;
    end else begin
      held_m = held_m & ~c;
      if (busy_m > 0) busy_m--;
    end
    if (cr) begin
      deadtime_m = 32'd0;
      dropped_m  = 16'd0;
    end else begin
      if (dead_pre) deadtime_m++;
      if (t && e && !acc) dropped_m++;
    end
    #1;
    trig_i = 1'b0; clear_i = 4'h0; cnt_reset_i = 1'b0;
    @(negedge clk125_i);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk125_i);
    #1 rst_i = 1'b0;
    reset_model();
    @(negedge clk125_i);
    check_all();
  endtask

  // Scoreboard: every DUT strobe must match the oldest expected allocation.
  always @(negedge clk125_i) begin
    exp_t e;
    if (!rst_i && digitize_o) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_buffer", {30'd0, digitize_buffer_o}, {30'd0, e.buf_idx});
        chk("sb_source", {28'd0, digitize_source_o}, {28'd0, e.src});
        chk("sb_status", {28'd0, buffer_status_o}, {28'd0, e.status});
      end
    end
  end

  initial begin
    reset_model();
    repeat (2) @(posedge clk125_i);
    @(negedge clk125_i);
    check_all();
    #1 rst_i = 1'b0;
    @(negedge clk125_i);
    check_all();

    // Basic sequence: accept, refuse at the last busy cycle, accept right after.
    idle(8);
    step(1'b1, 4'h3, 4'h0, 1'b1, 1'b0);
    chk("t1_buf", {30'd0, digitize_buffer_o}, 32'd0);
    chk("t1_status", {28'd0, buffer_status_o}, 32'h1);
    chk("t1_src", {28'd0, digitize_source_o}, 32'h3);
    idle(HOLDOFF);
    step(1'b1, 4'h7, 4'h0, 1'b1, 1'b0);
    chk("t1_drop", {16'd0, dropped_o}, 32'd1);
    step(1'b1, 4'h9, 4'h0, 1'b1, 1'b0);
    chk("t1_accept2", {31'd0, digitize_o}, 32'd1);
    idle(12);

    // Four spaced triggers fill all buffers in order.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'(k + 4), 4'h0, 1'b1, 1'b0);
      idle(12);
    end
    chk("t2_dead", {31'd0, dead_o}, 32'd1);

    // Dead period: 5 dropped triggers in 100 cycles, then counter clear.
    step(1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) step((i % 20) == 0, 4'hA, 4'h0, 1'b1, 1'b0);
    chk("t3_dropped", {16'd0, dropped_o}, 32'd5);
    chk("t3_deadtime", deadtime_o, 32'd100);
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("t3_disabled_ignored", {16'd0, dropped_o}, 32'd5);
    step(1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
    chk("t3_cnt_reset", {16'd0, dropped_o} | deadtime_o, 32'd0);

    // Clear coincident with trigger: trigger sees the pre-clear mask.
    step(1'b1, 4'hB, 4'b0100, 1'b1, 1'b0);
    step(1'b1, 4'hC, 4'h0, 1'b1, 1'b0);
    chk("t4_buf", {30'd0, digitize_buffer_o}, 32'd2);
    chk("t4_status", {28'd0, buffer_status_o}, 32'hF);
    idle(12);

    // Partial mask: release 1 and 3, allocate both, then release 0.
    step(1'b0, 4'h0, 4'b1010, 1'b1, 1'b0);
    step(1'b1, 4'h1, 4'h0, 1'b1, 1'b0);
    idle(12);
    step(1'b1, 4'h2, 4'h0, 1'b1, 1'b0);
    idle(12);
    step(1'b1, 4'h3, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 4'b0001, 1'b1, 1'b0);
    step(1'b1, 4'h4, 4'h0, 1'b1, 1'b0);
    chk("t5_buf0", {30'd0, digitize_buffer_o}, 32'd0);
    idle(12);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
           $urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0);
    end
    idle(12);

    // Asynchronous reset in the middle of a sequence.
    do_reset();
    step(1'b1, 4'h5, 4'h0, 1'b1, 1'b0);
    idle(2);
    @(posedge clk125_i);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_held", {28'd0, held_o}, 32'd0);
    chk("arst_status", {28'd0, buffer_status_o}, 32'd0);
    chk("arst_source", {28'd0, digitize_source_o}, 32'd0);
    chk("arst_digitize", {31'd0, digitize_o}, 32'd0);
    repeat (2) @(posedge clk125_i);
    #1 rst_i = 1'b0;
    reset_model();
    @(negedge clk125_i);
    check_all();
    step(1'b1, 4'h6, 4'h0, 1'b1, 1'b0);
    chk("arst_buf0", {30'd0, digitize_buffer_o}, 32'd0);
    chk("arst_strobe", {31'd0, digitize_o}, 32'd1);
    idle(12);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
